uart_cmd_frame_decoder: RTL and testbench



---
 rtl/is_pkg_uart_controller.sv | 26 ++
 rtl/uart_addr_region_dec.sv | 34 +++
 rtl/uart_cmd_frame_decoder.sv | 143 ++++++++++++++
 tb/tb_uart_cmd_frame_decoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/is_pkg_uart_controller.sv
// Shared UART controller definitions: region map, error codes, frame decoder states.
package is_pkg_uart_controller;

  localparam int NUM_REGIONS = 5;
  localparam int MAP_W       = 8;

  // Element 0 sits in the LSBs, so region 0 is the rightmost entry.
  localparam logic [NUM_REGIONS-1:0][MAP_W-1:0] REGION_BASE =
    {8'h40, 8'h29, 8'h19, 8'h08, 8'h00};
  localparam logic [NUM_REGIONS-1:0][MAP_W-1:0] REGION_END =
    {8'h4A, 8'h3F, 8'h28, 8'h18, 8'h07};

  typedef enum logic [1:0] {
    ERR_UNMAPPED = 2'd0,
    ERR_TIMEOUT  = 2'd1,
    ERR_OVERFLOW = 2'd2
  } err_code_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DECODE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/uart_addr_region_dec.sv
// Combinational address-to-region lookup; the lowest matching region index wins.
// Zero latency, no handshake.
module uart_addr_region_dec #(
  parameter int NUM_REGIONS = 5,
  parameter int ADDR_W      = 8,
  parameter int IDX_W       = 3,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] BASE = '0,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] LAST = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  index,
  output logic [ADDR_W-1:0] offset
);

  logic [ADDR_W-1:0] diff;

  always_comb begin
    hit    = 1'b0;
    index  = '0;
    offset = '0;
    diff   = '0;
    // Walk downwards so a lower-indexed match overrides any higher one.
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      diff = addr - BASE[i];
      if (diff <= (LAST[i] - BASE[i])) begin
        hit    = 1'b1;
        index  = IDX_W'(i);
        offset = diff;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_frame_decoder.sv
// Assembles fixed-length UART command frames, maps the address byte to a region and holds the command until cmd_ready.
// Last byte to cmd_valid: 2 cycles; bytes arriving while a frame is pending are dropped and flagged as overflow.
module uart_cmd_frame_decoder
  import is_pkg_uart_controller::*;
#(
  parameter int FRAME_BYTES = 6,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int NUM_REGIONS = is_pkg_uart_controller::NUM_REGIONS,
  parameter int TIMEOUT_CYC = 10000,
  parameter int REG_IDX_W   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE = is_pkg_uart_controller::REGION_BASE,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_END  = is_pkg_uart_controller::REGION_END
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_W-1:0]                 rx_data,
  input  logic                              rx_valid,
  output logic                              cmd_valid,
  input  logic                              cmd_ready,
  output logic [DATA_W-1:0]                 cmd_op,
  output logic [REG_IDX_W-1:0]              cmd_region,
  output logic [ADDR_W-1:0]                 cmd_offset,
  output logic [DATA_W*(FRAME_BYTES-2)-1:0] cmd_data,
  output logic                              err_valid,
  output logic [1:0]                        err_code,
  output logic [15:0]                       frame_cnt
);

  localparam int PAY_BYTES = FRAME_BYTES - 2;
  localparam int CNT_W     = $clog2(FRAME_BYTES);
  localparam int TO_W      = $clog2(TIMEOUT_CYC);

  state_t                              state;
  logic [FRAME_BYTES-1:0][DATA_W-1:0]  frame;
  logic [CNT_W-1:0]                    byte_cnt;
  logic [TO_W-1:0]                     to_cnt;
  logic [DATA_W*PAY_BYTES-1:0]         payload;
  logic                                map_hit;
  logic [REG_IDX_W-1:0]                map_index;
  logic [ADDR_W-1:0]                   map_offset;

  // Payload goes out MSB first: byte 2 lands in the top bits.
  always_comb begin
    payload = '0;
    for (int i = 0; i < PAY_BYTES; i++) begin
      payload[(PAY_BYTES-1-i)*DATA_W +: DATA_W] = frame[i+2];
    end
  end

  uart_addr_region_dec #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .IDX_W       (REG_IDX_W),
    .BASE        (REGION_BASE),
    .LAST        (REGION_END)
  ) u_region_dec (
    .addr   (frame[1]),
    .hit    (map_hit),
    .index  (map_index),
    .offset (map_offset)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      frame      <= '0;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      cmd_valid  <= 1'b0;
      cmd_op     <= '0;
      cmd_region <= '0;
      cmd_offset <= '0;
      cmd_data   <= '0;
      err_valid  <= 1'b0;
      err_code   <= ERR_UNMAPPED;
      frame_cnt  <= '0;
    end else begin
      err_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            frame[0] <= rx_data;
            byte_cnt <= CNT_W'(1);
            to_cnt   <= '0;
            state    <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (rx_valid) begin
            frame[byte_cnt] <= rx_data;
            byte_cnt        <= byte_cnt + CNT_W'(1);
            to_cnt          <= '0;
            if (byte_cnt == CNT_W'(FRAME_BYTES - 1)) begin
              state <= ST_DECODE;
            end
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        ST_DECODE: begin
          if (map_hit) begin
            cmd_valid  <= 1'b1;
            cmd_op     <= frame[0];
            cmd_region <= map_index;
            cmd_offset <= map_offset;
            cmd_data   <= payload;
            state      <= ST_HOLD;
            if (rx_valid) begin
              err_valid <= 1'b1;
              err_code  <= ERR_OVERFLOW;
            end
          end else begin
            err_valid <= 1'b1;
            err_code  <= ERR_UNMAPPED;
            state     <= ST_IDLE;
          end
        end

        ST_HOLD: begin
          if (rx_valid) begin
            err_valid <= 1'b1;
            err_code  <= ERR_OVERFLOW;
          end
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_frame_decoder.sv
// Randomized frame stimulus checked against a frame-level reference of the region map and handshake timing.
module tb_uart_cmd_frame_decoder;

  localparam int TO = 10000;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [2:0]  cmd_region;
  logic [7:0]  cmd_offset;
  logic [31:0] cmd_data;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_cnt  = '0;
  logic [1:0]  exp_err  = '0;

  int ref_base[5] = '{8'h00, 8'h08, 8'h19, 8'h29, 8'h40};
  int ref_last[5] = '{8'h07, 8'h18, 8'h28, 8'h3F, 8'h4A};

  uart_cmd_frame_decoder #(
    .FRAME_BYTES (6),
    .DATA_W      (8),
    .ADDR_W      (8),
    .NUM_REGIONS (5),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_region (cmd_region),
    .cmd_offset (cmd_offset),
    .cmd_data   (cmd_data),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .frame_cnt  (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // All stimulus advances in whole cycles and resumes 1 ns after the rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  function automatic int ref_region(input int a);
    for (int i = 0; i < 5; i++) begin
      if (a >= ref_base[i] && a <= ref_last[i]) return i;
    end
    return -1;
  endfunction

  task automatic run_frame(input logic [7:0] op, input logic [7:0] addr, input logic [31:0] pay,
                           input int gap_max, input int slow_idx, input int slow_gap,
                           input int hold_cyc, input bit ovf, input string tag);
    logic [7:0] b[6];
    logic [7:0] exp_off;
    int r;
    b = '{op, addr, pay[31:24], pay[23:16], pay[15:8], pay[7:0]};
    cmd_ready = (hold_cyc == 0);
    for (int i = 0; i < 6; i++) begin
      idle((i == slow_idx) ? slow_gap : int'($urandom_range(gap_max, 0)));
      strobe(b[i]);
    end
    chk({tag, "/decode_quiet"}, {62'd0, err_valid, cmd_valid}, 64'd0);
    idle(1);
    r = ref_region(int'(addr));
    if (r < 0) begin
      chk({tag, "/miss_err"}, {60'd0, cmd_valid, err_valid, err_code}, {60'd0, 1'b0, 1'b1, 2'd0});
      exp_err = 2'd0;
      idle(1);
      chk({tag, "/miss_pulse_end"}, {63'd0, err_valid}, 64'd0);
      cmd_ready = 1'b0;
    end else begin
      exp_off = addr - 8'(ref_base[r]);
      chk({tag, "/valid"}, {62'd0, cmd_valid, err_valid}, {62'd0, 1'b1, 1'b0});
      chk({tag, "/fields"}, {13'd0, cmd_op, cmd_region, cmd_offset, cmd_data},
          {13'd0, op, 3'(r), exp_off, pay});
      if (hold_cyc > 0) begin
        idle(1);
        if (ovf) begin
          strobe(8'h55);
          exp_err = 2'd2;
          chk({tag, "/ovf_err"}, {61'd0, err_valid, err_code}, {61'd0, 1'b1, 2'd2});
          idle(1);
          chk({tag, "/ovf_pulse_end"}, {63'd0, err_valid}, 64'd0);
        end
        idle(hold_cyc);
        chk({tag, "/held"}, {12'd0, cmd_valid, cmd_op, cmd_region, cmd_offset, cmd_data},
            {12'd0, 1'b1, op, 3'(r), exp_off, pay});
        cmd_ready = 1'b1;
      end
      idle(1);
      cmd_ready = 1'b0;
      exp_cnt   = exp_cnt + 16'd1;
      chk({tag, "/accepted"}, {63'd0, cmd_valid}, 64'd0);
      chk({tag, "/frame_cnt"}, {48'd0, frame_cnt}, {48'd0, exp_cnt});
      chk({tag, "/err_code_kept"}, {62'd0, err_code}, {62'd0, exp_err});
    end
  endtask

  initial begin
    rst       = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    cmd_ready = 1'b0;
    #1 rst = 1'b1;
    idle(1);
    chk("reset_outputs", {25'd0, cmd_valid, err_valid, err_code, frame_cnt, cmd_op, cmd_region, cmd_offset}, 64'd0);
    chk("reset_data", {32'd0, cmd_data}, 64'd0);
    idle(2);
    rst = 1'b0;
    idle(2);

    run_frame(8'h57, 8'h1A, 32'hDEADBEEF, 0, -1, 0, 0, 1'b0, "basic");
    run_frame(8'h21, 8'h4B, 32'h01020304, 0, -1, 0, 0, 1'b0, "unmapped");
    run_frame(8'h22, 8'h30, 32'hCAFEF00D, 1, -1, 0, 0, 1'b0, "after_miss");

    strobe(8'h11);
    strobe(8'h22);
    strobe(8'h33);
    idle(TO - 1);
    chk("timeout_early", {63'd0, err_valid}, 64'd0);
    idle(1);
    chk("timeout_err", {61'd0, err_valid, err_code}, {61'd0, 1'b1, 2'd1});
    exp_err = 2'd1;
    idle(1);
    chk("timeout_pulse_end", {63'd0, err_valid}, 64'd0);
    run_frame(8'h3C, 8'h00, 32'h12345678, 2, -1, 0, 0, 1'b0, "after_timeout");

    run_frame(8'h77, 8'h2A, 32'hA5A55A5A, 0, -1, 0, 20, 1'b1, "hold_overflow");

    run_frame(8'h01, 8'h07, 32'h00000007, 0, -1, 0, 0, 1'b0, "bound_07");
    run_frame(8'h02, 8'h08, 32'h00000008, 0, -1, 0, 0, 1'b0, "bound_08");
    run_frame(8'h03, 8'h3F, 32'h0000003F, 0, -1, 0, 0, 1'b0, "bound_3f");
    run_frame(8'h04, 8'h40, 32'h00000040, 0, -1, 0, 0, 1'b0, "bound_40");
    run_frame(8'h05, 8'h4A, 32'h0000004A, 0, -1, 0, 0, 1'b0, "bound_4a");

    run_frame(8'h66, 8'h10, 32'h0BADF00D, 0, 3, TO - 1, 0, 1'b0, "late_byte");

    strobe(8'h99);
    strobe(8'h12);
    strobe(8'h34);
    strobe(8'h56);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {25'd0, cmd_valid, err_valid, err_code, frame_cnt, cmd_op, cmd_region, cmd_offset}, 64'd0);
    chk("rst_mid_data", {32'd0, cmd_data}, 64'd0);
    idle(1);
    rst = 1'b0;
    exp_cnt = '0;
    exp_err = '0;
    idle(1);
    run_frame(8'h5A, 8'h1A, 32'hFEEDFACE, 0, -1, 0, 0, 1'b0, "after_reset");

    for (int k = 0; k < 40; k++) begin
      logic [7:0]  op;
      logic [7:0]  addr;
      logic [31:0] pay;
      int          hold;
      bit          ovf;
      op   = 8'($urandom);
      addr = 8'($urandom_range(8'h5F, 0));
      pay  = $urandom;
      hold = int'($urandom_range(4, 0));
      ovf  = (hold > 0) && ($urandom_range(1, 0) == 1);
      run_frame(op, addr, pay, 3, -1, 0, hold, ovf, $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
